// File: rtl/riscv_pkg.sv
// Shared pipeline types: opcodes, forwarding selects, hazard FSM states and
// the per-stage shadow record, plus opcode decode helpers.
package riscv_pkg;

  typedef enum logic [6:0] {
    LOAD    = 7'b0000011,
    REG_IMM = 7'b0010011,
    STORE   = 7'b0100011,
    REG_REG = 7'b0110011,
    BRANCH  = 7'b1100011
  } opcode_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hazard_state_t;

  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       is_load;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
  } shadow_t;

  function automatic logic writes_rd(input opcode_t op);
    return (op == REG_IMM) || (op == REG_REG) || (op == LOAD);
  endfunction

  function automatic logic reads_rs1(input opcode_t op);
    return (op == REG_IMM) || (op == REG_REG) || (op == LOAD) ||
           (op == STORE) || (op == BRANCH);
  endfunction

  function automatic logic reads_rs2(input opcode_t op);
    return (op == REG_REG) || (op == STORE) || (op == BRANCH);
  endfunction

endpackage

// File: rtl/riscv_fwd_unit.sv
// Operand source select for one EX source register; MEM/WB results are
// matched by rd, the nearer (MEM) stage wins and x0 is never forwarded.
module riscv_fwd_unit
  import riscv_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_wr,
  input  logic [4:0] mem_rd,
  input  logic       wb_wr,
  input  logic [4:0] wb_rd,
  output fwd_sel_t   sel
);

  always_comb begin
    sel = FWD_RF;
    if (src != 5'd0) begin
      if (mem_wr && (mem_rd == src))     sel = FWD_MEM;
      else if (wb_wr && (wb_rd == src))  sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks EX/MEM/WB shadow records, drives
// forwarding, load-use stall, branch flush and memory-wait freeze.
module hazard_ctrl
  import riscv_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  opcode_t          id_opcode,
  input  logic [4:0]       id_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             stall_if,
  output logic             stall_id,
  output logic             bubble_ex,
  output logic             flush_id,
  output logic             flush_ex,
  output logic             freeze_ex_mem,
  output fwd_sel_t         fwd_a,
  output fwd_sel_t         fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  hazard_state_t state;
  shadow_t       ex_q, mem_q, wb_q, id_rec;
  logic          id_rd1, id_rd2, load_use, freeze, flush, lu_stall;

  always_comb begin
    id_rd1         = id_valid && reads_rs1(id_opcode);
    id_rd2         = id_valid && reads_rs2(id_opcode);
    id_rec         = '0;
    id_rec.valid   = id_valid;
    id_rec.wr      = id_valid && writes_rd(id_opcode);
    id_rec.is_load = id_valid && (id_opcode == LOAD);
    id_rec.rd      = id_rd;
    id_rec.rs1     = id_rd1 ? id_rs1 : 5'd0;
    id_rec.rs2     = id_rd2 ? id_rs2 : 5'd0;
  end

  assign load_use = ex_q.is_load && (ex_q.rd != 5'd0) &&
                    ((id_rd1 && (id_rs1 == ex_q.rd)) ||
                     (id_rd2 && (id_rs2 == ex_q.rd)));

  // The miss cycle itself freezes; the ready cycle releases so the transfer completes.
  assign freeze   = rst_n && !mem_ready && ((state == MEM_WAIT) || mem_req);
  assign flush    = rst_n && !freeze && ex_branch_taken;
  assign lu_stall = rst_n && !freeze && !flush && load_use;

  assign freeze_ex_mem = freeze;
  assign stall_if      = freeze || lu_stall;
  assign stall_id      = freeze || lu_stall;
  assign bubble_ex     = lu_stall;
  assign flush_id      = flush;
  assign flush_ex      = flush;

  riscv_fwd_unit u_fwd_a (
    .src(ex_q.rs1), .mem_wr(mem_q.wr), .mem_rd(mem_q.rd),
    .wb_wr(wb_q.wr), .wb_rd(wb_q.rd), .sel(fwd_a)
  );

  riscv_fwd_unit u_fwd_b (
    .src(ex_q.rs2), .mem_wr(mem_q.wr), .mem_rd(mem_q.rd),
    .wb_wr(wb_q.wr), .wb_rd(wb_q.rd), .sel(fwd_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:      if (mem_req && !mem_ready) state <= MEM_WAIT;
        MEM_WAIT: if (mem_ready)             state <= RUN;
        default:                             state <= RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (!freeze) begin
      ex_q  <= (lu_stall || flush) ? '0 : id_rec;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1))    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  // Record fields kept for completeness but not consumed by any hazard check.
  logic unused_fields;
  assign unused_fields = ^{ex_q.valid, ex_q.wr, mem_q.valid, mem_q.is_load,
                           mem_q.rs1, mem_q.rs2, wb_q.valid, wb_q.is_load,
                           wb_q.rs1, wb_q.rs2};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding, load-use, branch flush,
// memory freeze, x0 handling, counter saturation and reset.
module tb_hazard_ctrl;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, ex_branch_taken, mem_req, mem_ready;
  opcode_t id_opcode;
  logic [4:0] id_rd, id_rs1, id_rs2;
  logic stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze_ex_mem;
  fwd_sel_t fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;
  logic s_stall_if, s_stall_id, s_bubble_ex, s_flush_id, s_flush_ex, s_freeze;
  fwd_sel_t s_fwd_a, s_fwd_b;
  logic [1:0] s_stall_cnt, s_flush_cnt;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_id(stall_id), .bubble_ex(bubble_ex),
    .flush_id(flush_id), .flush_ex(flush_ex), .freeze_ex_mem(freeze_ex_mem),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_branch_taken(ex_branch_taken), .mem_req(mem_req), .mem_ready(mem_ready),
    .stall_if(s_stall_if), .stall_id(s_stall_id), .bubble_ex(s_bubble_ex),
    .flush_id(s_flush_id), .flush_ex(s_flush_ex), .freeze_ex_mem(s_freeze),
    .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input opcode_t op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid = v; id_opcode = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
  endtask

  task automatic drain();
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b1; ex_branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
    set_id(1'b1, REG_REG, 5'd3, 5'd1, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    total++; if ({stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze_ex_mem} !== 6'b0) begin bad++; $display("FAIL reset_ctrl got=%b exp=000000", {stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze_ex_mem}); end
    total++; if ({fwd_a, fwd_b} !== 4'b0) begin bad++; $display("FAIL reset_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    ex_branch_taken = 1'b0; mem_req = 1'b0;
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_forward();
    tick();
    set_id(1'b1, REG_REG, 5'd5, 5'd1, 5'd2);
    tick();
    set_id(1'b1, REG_REG, 5'd6, 5'd5, 5'd3);
    #1;
    total++; if (stall_id !== 1'b0) begin bad++; $display("FAIL fwd_nostall got=%b exp=0", stall_id); end
    tick();
    set_id(1'b1, REG_REG, 5'd7, 5'd5, 5'd5);
    #1;
    total++; if (fwd_a !== FWD_MEM || fwd_b !== FWD_RF) begin bad++; $display("FAIL fwd_mem got=%0d/%0d exp=1/0", fwd_a, fwd_b); end
    tick();
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    #1;
    total++; if (fwd_a !== FWD_WB || fwd_b !== FWD_WB) begin bad++; $display("FAIL fwd_wb got=%0d/%0d exp=2/2", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1'b1, LOAD, 5'd5, 5'd1, 5'd0);
    tick();
    set_id(1'b1, REG_REG, 5'd6, 5'd5, 5'd2);
    #1;
    total++; if ({stall_if, stall_id, bubble_ex} !== 3'b111) begin bad++; $display("FAIL lu_stall got=%b exp=111", {stall_if, stall_id, bubble_ex}); end
    tick();
    #1;
    total++; if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin bad++; $display("FAIL lu_once got=%b exp=000", {stall_if, stall_id, bubble_ex}); end
    total++; if (stall_cnt !== 16'd1) begin bad++; $display("FAIL lu_cnt got=%0d exp=1", stall_cnt); end
    tick();
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    #1;
    total++; if (fwd_a !== FWD_WB || fwd_b !== FWD_RF) begin bad++; $display("FAIL lu_fwd got=%0d/%0d exp=2/0", fwd_a, fwd_b); end
    drain();
  endtask

  task automatic test_branch();
    set_id(1'b1, LOAD, 5'd5, 5'd1, 5'd0);
    tick();
    set_id(1'b1, REG_REG, 5'd6, 5'd5, 5'd2);
    ex_branch_taken = 1'b1;
    #1;
    total++; if ({flush_id, flush_ex} !== 2'b11) begin bad++; $display("FAIL br_flush got=%b exp=11", {flush_id, flush_ex}); end
    total++; if ({stall_if, stall_id, bubble_ex} !== 3'b000) begin bad++; $display("FAIL br_nostall got=%b exp=000", {stall_if, stall_id, bubble_ex}); end
    tick();
    ex_branch_taken = 1'b0;
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    #1;
    total++; if (flush_cnt !== 16'd1 || flush_id !== 1'b0) begin bad++; $display("FAIL br_cnt got=%0d/%b exp=1/0", flush_cnt, flush_id); end
    total++; if (stall_cnt !== 16'd1 || stall_id !== 1'b0) begin bad++; $display("FAIL br_stallcnt got=%0d/%b exp=1/0", stall_cnt, stall_id); end
    drain();
  endtask

  task automatic test_mem_wait();
    set_id(1'b1, REG_REG, 5'd5, 5'd1, 5'd2);
    tick();
    set_id(1'b1, REG_REG, 5'd6, 5'd5, 5'd3);
    tick();
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++; if ({freeze_ex_mem, stall_if, stall_id} !== 3'b111) begin bad++; $display("FAIL mw_freeze%0d got=%b exp=111", i, {freeze_ex_mem, stall_if, stall_id}); end
      total++; if ({flush_id, flush_ex, bubble_ex} !== 3'b000) begin bad++; $display("FAIL mw_noflush%0d got=%b exp=000", i, {flush_id, flush_ex, bubble_ex}); end
      total++; if (fwd_a !== FWD_MEM) begin bad++; $display("FAIL mw_fwd%0d got=%0d exp=1", i, fwd_a); end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++; if ({freeze_ex_mem, flush_id, flush_ex} !== 3'b011) begin bad++; $display("FAIL mw_release got=%b exp=011", {freeze_ex_mem, flush_id, flush_ex}); end
    total++; if (stall_cnt !== 16'd4 || flush_cnt !== 16'd1) begin bad++; $display("FAIL mw_cnt got=%0d/%0d exp=4/1", stall_cnt, flush_cnt); end
    tick();
    mem_req = 1'b0; mem_ready = 1'b0; ex_branch_taken = 1'b0;
    #1;
    total++; if (freeze_ex_mem !== 1'b0 || flush_cnt !== 16'd2) begin bad++; $display("FAIL mw_run got=%b/%0d exp=0/2", freeze_ex_mem, flush_cnt); end
    drain();
  endtask

  task automatic test_x0();
    set_id(1'b1, LOAD, 5'd0, 5'd1, 5'd0);
    tick();
    set_id(1'b1, REG_REG, 5'd1, 5'd0, 5'd0);
    #1;
    total++; if ({stall_id, bubble_ex} !== 2'b00) begin bad++; $display("FAIL x0_nostall got=%b exp=00", {stall_id, bubble_ex}); end
    tick();
    set_id(1'b0, REG_REG, 5'd0, 5'd0, 5'd0);
    tick();
    total++; if ({fwd_a, fwd_b} !== 4'b0) begin bad++; $display("FAIL x0_fwd got=%b exp=0000", {fwd_a, fwd_b}); end
    drain();
  endtask

  task automatic test_saturate();
    total++; if (s_stall_cnt !== 2'd3 || s_flush_cnt !== 2'd2) begin bad++; $display("FAIL sat_cnt got=%0d/%0d exp=3/2", s_stall_cnt, s_flush_cnt); end
  endtask

  task automatic test_reset_mid_wait();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch_taken = 1'b1;
    tick(); tick();
    #1;
    total++; if (freeze_ex_mem !== 1'b1) begin bad++; $display("FAIL rw_pre got=%b exp=1", freeze_ex_mem); end
    rst_n = 1'b0;
    #1;
    total++; if ({stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze_ex_mem, fwd_a, fwd_b} !== 10'b0) begin bad++; $display("FAIL rw_outs got=%b exp=0", {stall_if, stall_id, bubble_ex, flush_id, flush_ex, freeze_ex_mem, fwd_a, fwd_b}); end
    total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL rw_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    mem_req = 1'b0; ex_branch_taken = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (freeze_ex_mem !== 1'b0) begin bad++; $display("FAIL rw_run got=%b exp=0", freeze_ex_mem); end
    tick();
    total++; if (freeze_ex_mem !== 1'b0 || stall_cnt !== 16'd0) begin bad++; $display("FAIL rw_after got=%b/%0d exp=0/0", freeze_ex_mem, stall_cnt); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_x0();
    test_saturate();
    test_reset_mid_wait();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
